// File: rtl/cp0_pkg.sv
// Shared CP0 constants: register numbers, ExcCode values, Status/Cause field positions and write masks.
package cp0_pkg;

    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;

    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0a;
    localparam logic [4:0] EXC_OV   = 5'h0c;

    localparam int STATUS_IE  = 0;
    localparam int STATUS_EXL = 1;
    localparam int STATUS_BEV = 22;

    localparam logic [31:0] STATUS_WMASK    = 32'h0000_FF03;
    localparam logic [31:0] STATUS_BEV_MASK = 32'h0040_0000;
    localparam logic [31:0] CAUSE_WMASK     = 32'h0000_0300;

endpackage

// File: rtl/cp0_timer.sv
// CP0 Count/Compare timer: prescaled Count, Compare register and sticky timer-interrupt flag.
module cp0_timer #(
    parameter int CNT_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);

    localparam int              DW       = (CNT_DIV > 1) ? $clog2(CNT_DIV) : 1;
    localparam logic [DW-1:0]   DIV_LAST = DW'(CNT_DIV - 1);

    logic [DW-1:0] div_q;
    logic          div_wrap;

    assign div_wrap = (div_q == DIV_LAST);

    // A Count write restarts the prescaler; a Compare write acknowledges the interrupt.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q   <= '0;
            count   <= '0;
            compare <= '0;
            ti      <= 1'b0;
        end else begin
            if (count_we) begin
                count <= wdata;
                div_q <= '0;
            end else begin
                div_q <= div_wrap ? '0 : div_q + DW'(1);
                if (div_wrap)
                    count <= count + 32'd1;
            end
            if (compare_we)
                compare <= wdata;
            if (compare_we)
                ti <= 1'b0;
            else if (count == compare)
                ti <= 1'b1;
        end
    end

endmodule

// File: rtl/cp0_regfile.sv
// CP0 register file: Status/Cause/EPC/BadVAddr with exception, ERET and MTC0 updates.
// Define CP0_TIMER_EN to add the Count/Compare timer (cp0_timer) and its interrupt.
module cp0_regfile
    import cp0_pkg::*;
#(
    parameter logic [31:0] STATUS_RST = 32'h0040_0000,
    parameter int          CNT_DIV    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mtc0_we,
    input  logic [4:0]  mtc0_addr,
    input  logic [31:0] mtc0_wdata,
    input  logic [4:0]  mfc0_addr,
    output logic [31:0] mfc0_rdata,
    input  logic        exc_occur,
    input  logic [4:0]  exc_code,
    input  logic        exc_is_ds,
    input  logic [31:0] exc_epc,
    input  logic        exc_badva_we,
    input  logic [31:0] exc_badva,
    input  logic        eret,
    input  logic [5:0]  hw_int,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic        int_pending
);

    logic [31:0] status_q;
    logic [31:0] epc_q;
    logic [31:0] badva_q;
    logic        cause_bd_q;
    logic [4:0]  cause_code_q;
    logic [1:0]  ip_sw_q;
    logic [5:0]  ip_hw_q;
    logic        ti;
    logic        mtc0_commit;

    assign mtc0_commit = mtc0_we & ~exc_occur & ~eret;

`ifdef CP0_TIMER_EN
    logic [31:0] count;
    logic [31:0] compare;

    cp0_timer #(.CNT_DIV(CNT_DIV)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .count_we   (mtc0_commit && (mtc0_addr == CP0_COUNT)),
        .compare_we (mtc0_commit && (mtc0_addr == CP0_COMPARE)),
        .wdata      (mtc0_wdata),
        .count      (count),
        .compare    (compare),
        .ti         (ti)
    );
`else
    assign ti = 1'b0;
`endif

    // Exception commit outranks ERET, which outranks MTC0; a losing write is dropped entirely.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status_q     <= STATUS_RST & STATUS_WMASK;
            epc_q        <= '0;
            badva_q      <= '0;
            cause_bd_q   <= 1'b0;
            cause_code_q <= '0;
            ip_sw_q      <= '0;
            ip_hw_q      <= '0;
        end else begin
            ip_hw_q <= {hw_int[5] | ti, hw_int[4:0]};
            if (exc_occur) begin
                status_q[STATUS_EXL] <= 1'b1;
                cause_bd_q           <= exc_is_ds;
                cause_code_q         <= exc_code;
                epc_q                <= exc_epc;
                if (exc_badva_we)
                    badva_q <= exc_badva;
            end else if (eret) begin
                status_q[STATUS_EXL] <= 1'b0;
            end else if (mtc0_we) begin
                case (mtc0_addr)
                    CP0_STATUS: status_q <= mtc0_wdata & STATUS_WMASK;
                    CP0_CAUSE:  ip_sw_q  <= mtc0_wdata[9:8];
                    CP0_EPC:    epc_q    <= mtc0_wdata;
                    default:    ;
                endcase
            end
        end
    end

    assign status_o = status_q | STATUS_BEV_MASK;
    assign cause_o  = {cause_bd_q, ti, 14'd0, ip_hw_q, ip_sw_q, 1'b0, cause_code_q, 2'b00};
    assign epc_o    = epc_q;

    assign int_pending = status_q[STATUS_IE] & ~status_q[STATUS_EXL]
                       & (|(cause_o[15:8] & status_q[15:8]));

    always_comb begin
        mfc0_rdata = '0;
        case (mfc0_addr)
            CP0_BADVADDR: mfc0_rdata = badva_q;
`ifdef CP0_TIMER_EN
            CP0_COUNT:    mfc0_rdata = count;
            CP0_COMPARE:  mfc0_rdata = compare;
`endif
            CP0_STATUS:   mfc0_rdata = status_o;
            CP0_CAUSE:    mfc0_rdata = cause_o;
            CP0_EPC:      mfc0_rdata = epc_o;
            default:      mfc0_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0_regfile.sv
// Self-checking bench for cp0_regfile: per-cycle reference model plus directed literal checks.
module tb_cp0_regfile;

    localparam int CNT_DIV = 2;

    logic        clk;
    logic        rst;
    logic        mtc0_we;
    logic [4:0]  mtc0_addr;
    logic [31:0] mtc0_wdata;
    logic [4:0]  mfc0_addr;
    logic [31:0] mfc0_rdata;
    logic        exc_occur;
    logic [4:0]  exc_code;
    logic        exc_is_ds;
    logic [31:0] exc_epc;
    logic        exc_badva_we;
    logic [31:0] exc_badva;
    logic        eret;
    logic [5:0]  hw_int;
    logic [31:0] status_o;
    logic [31:0] cause_o;
    logic [31:0] epc_o;
    logic        int_pending;

    int total = 0;
    int bad   = 0;

    cp0_regfile #(.STATUS_RST(32'h0040_0000), .CNT_DIV(CNT_DIV)) dut (
        .clk          (clk),
        .rst          (rst),
        .mtc0_we      (mtc0_we),
        .mtc0_addr    (mtc0_addr),
        .mtc0_wdata   (mtc0_wdata),
        .mfc0_addr    (mfc0_addr),
        .mfc0_rdata   (mfc0_rdata),
        .exc_occur    (exc_occur),
        .exc_code     (exc_code),
        .exc_is_ds    (exc_is_ds),
        .exc_epc      (exc_epc),
        .exc_badva_we (exc_badva_we),
        .exc_badva    (exc_badva),
        .eret         (eret),
        .hw_int       (hw_int),
        .status_o     (status_o),
        .cause_o      (cause_o),
        .epc_o        (epc_o),
        .int_pending  (int_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: architectural register contents as plain values.
    logic [31:0] m_status, m_epc, m_badva, m_count, m_compare;
    logic        m_bd, m_ti;
    logic [4:0]  m_code;
    logic [1:0]  m_ipsw;
    logic [5:0]  m_iphw;
    int          m_ticks;
    logic        m_mt;
    logic [31:0] old_count, old_compare;
    logic        old_ti;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_status = 32'h0040_0000; m_epc = 0; m_badva = 0; m_count = 0; m_compare = 0;
            m_bd = 0; m_ti = 0; m_code = 0; m_ipsw = 0; m_iphw = 0; m_ticks = 0;
        end else begin
            m_mt        = mtc0_we && !exc_occur && !eret;
            old_count   = m_count;
            old_compare = m_compare;
            old_ti      = m_ti;
            m_iphw = {hw_int[5] | old_ti, hw_int[4:0]};
            if (exc_occur) begin
                m_status[1] = 1'b1;
                m_bd   = exc_is_ds;
                m_code = exc_code;
                m_epc  = exc_epc;
                if (exc_badva_we) m_badva = exc_badva;
            end else if (eret) begin
                m_status[1] = 1'b0;
            end else if (mtc0_we) begin
                if (mtc0_addr == 5'd12) m_status = (mtc0_wdata & 32'h0000_FF03) | 32'h0040_0000;
                if (mtc0_addr == 5'd13) m_ipsw = mtc0_wdata[9:8];
                if (mtc0_addr == 5'd14) m_epc = mtc0_wdata;
            end
`ifdef CP0_TIMER_EN
            if (m_mt && mtc0_addr == 5'd9) begin
                m_count = mtc0_wdata;
                m_ticks = 0;
            end else begin
                m_ticks = m_ticks + 1;
                if (m_ticks == CNT_DIV) begin
                    m_ticks = 0;
                    m_count = m_count + 1;
                end
            end
            if (m_mt && mtc0_addr == 5'd11) begin
                m_compare = mtc0_wdata;
                m_ti = 0;
            end else if (old_count == old_compare) begin
                m_ti = 1;
            end
`endif
        end
    end

    function automatic logic [31:0] exp_cause();
        return {m_bd, m_ti, 14'd0, m_iphw, m_ipsw, 1'b0, m_code, 2'b00};
    endfunction

    function automatic logic [31:0] exp_read(input logic [4:0] a);
        case (a)
            5'd8:  return m_badva;
`ifdef CP0_TIMER_EN
            5'd9:  return m_count;
            5'd11: return m_compare;
`endif
            5'd12: return m_status;
            5'd13: return exp_cause();
            5'd14: return m_epc;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic exp_int();
        logic [31:0] c;
        c = exp_cause();
        return m_status[0] & ~m_status[1] & (|(c[15:8] & m_status[15:8]));
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        checkOutput("cyc_status", status_o, m_status);
        checkOutput("cyc_cause", cause_o, exp_cause());
        checkOutput("cyc_epc", epc_o, m_epc);
        checkOutput("cyc_mfc0", mfc0_rdata, exp_read(mfc0_addr));
        checkOutput("cyc_intpend", {31'd0, int_pending}, {31'd0, exp_int()});
    end

    task automatic cycle();
        @(negedge clk);
        #2;
    endtask

    task automatic applyStimulus(input logic we, input logic [4:0] addr, input logic [31:0] data);
        mtc0_we    = we;
        mtc0_addr  = addr;
        mtc0_wdata = data;
        cycle();
        mtc0_we      = 1'b0;
        exc_occur    = 1'b0;
        exc_badva_we = 1'b0;
        eret         = 1'b0;
    endtask

    initial begin
        rst = 0; mtc0_we = 0; mtc0_addr = 0; mtc0_wdata = 0; mfc0_addr = 5'd8;
        exc_occur = 0; exc_code = 0; exc_is_ds = 0; exc_epc = 0;
        exc_badva_we = 0; exc_badva = 0; eret = 0; hw_int = 0;
        #1 rst = 1;
        #1;
        checkOutput("rst_status", status_o, 32'h0040_0000);
        checkOutput("rst_cause", cause_o, 32'h0000_0000);
        checkOutput("rst_epc", epc_o, 32'h0000_0000);
        checkOutput("rst_badva", mfc0_rdata, 32'h0000_0000);
        checkOutput("rst_intpend", {31'd0, int_pending}, 32'd0);
        cycle(); cycle();
        rst = 0;
        applyStimulus(1, 5'd11, 32'hFFFF_0000);
        cycle();

        // Status/Cause write masks and no read bypass
        mfc0_addr = 5'd12;
        mtc0_we = 1; mtc0_addr = 5'd12; mtc0_wdata = 32'hFFFF_FFFF;
        #1 checkOutput("no_bypass", mfc0_rdata, 32'h0040_0000);
        applyStimulus(1, 5'd12, 32'hFFFF_FFFF);
        checkOutput("status_mask", status_o, 32'h0040_FF03);
        checkOutput("status_read", mfc0_rdata, 32'h0040_FF03);
        applyStimulus(1, 5'd13, 32'hFFFF_FFFF);
        checkOutput("cause_mask", cause_o, 32'h0000_0300);
        applyStimulus(1, 5'd13, 32'h0);
        applyStimulus(1, 5'd12, 32'h0);
        checkOutput("status_clr", status_o, 32'h0040_0000);

        // Exception commit beats same-cycle MTC0
        mfc0_addr = 5'd8;
        exc_occur = 1; exc_code = 5'h04; exc_is_ds = 1; exc_epc = 32'hBFC0_0100;
        exc_badva_we = 1; exc_badva = 32'h0000_0003;
        applyStimulus(1, 5'd14, 32'h0000_1234);
        checkOutput("exc_cause", cause_o, 32'h8000_0010);
        checkOutput("exc_epc", epc_o, 32'hBFC0_0100);
        checkOutput("exc_badva", mfc0_rdata, 32'h0000_0003);
        checkOutput("exc_status", status_o, 32'h0040_0002);

        // ERET alone, then ERET together with an exception
        eret = 1;
        applyStimulus(0, 5'd0, 32'h0);
        checkOutput("eret_status", status_o, 32'h0040_0000);
        checkOutput("eret_epc", epc_o, 32'hBFC0_0100);
        eret = 1; exc_occur = 1; exc_code = 5'h0c; exc_is_ds = 0; exc_epc = 32'h8000_0180;
        applyStimulus(0, 5'd0, 32'h0);
        checkOutput("exc_eret_status", status_o, 32'h0040_0002);
        checkOutput("exc_eret_cause", cause_o, 32'h0000_0030);
        checkOutput("exc_eret_epc", epc_o, 32'h8000_0180);
        checkOutput("exc_eret_badva", mfc0_rdata, 32'h0000_0003);

        // Interrupt sampling and masking
        eret = 1;
        applyStimulus(0, 5'd0, 32'h0);
        hw_int = 6'b000001;
        applyStimulus(1, 5'd12, 32'h0000_8001);
        checkOutput("ip2_cause", cause_o, 32'h0000_0430);
        checkOutput("ip2_masked", {31'd0, int_pending}, 32'd0);
        hw_int = 6'b100000;
        cycle();
        checkOutput("ip7_cause", cause_o, 32'h0000_8030);
        checkOutput("ip7_pending", {31'd0, int_pending}, 32'd1);
        exc_occur = 1; exc_code = 5'h00; exc_epc = 32'h0000_0100;
        applyStimulus(0, 5'd0, 32'h0);
        checkOutput("exl_blocks", {31'd0, int_pending}, 32'd0);
        hw_int = 0;
        eret = 1;
        applyStimulus(0, 5'd0, 32'h0);
        cycle();

        // Unimplemented register number
        mfc0_addr = 5'd20;
        applyStimulus(1, 5'd20, 32'hDEAD_BEEF);
        checkOutput("unimpl_read", mfc0_rdata, 32'h0);

`ifdef CP0_TIMER_EN
        mfc0_addr = 5'd9;
        applyStimulus(1, 5'd9, 32'h0);
        applyStimulus(1, 5'd11, 32'd10);
        repeat (19) cycle();
        checkOutput("count_10", mfc0_rdata, 32'd10);
        checkOutput("ti_not_yet", {31'd0, cause_o[30]}, 32'd0);
        cycle();
        checkOutput("ti_set", {31'd0, cause_o[30]}, 32'd1);
        cycle();
        checkOutput("ip7_timer", {31'd0, cause_o[15]}, 32'd1);
        applyStimulus(1, 5'd11, 32'd5);
        checkOutput("ti_clear", {31'd0, cause_o[30]}, 32'd0);
        applyStimulus(1, 5'd9, 32'hFFFF_FFFF);
        checkOutput("count_load", mfc0_rdata, 32'hFFFF_FFFF);
        cycle(); cycle();
        checkOutput("count_wrap", mfc0_rdata, 32'h0);
`endif

        // Asynchronous reset mid-operation
        mtc0_we = 1; mtc0_addr = 5'd12; mtc0_wdata = 32'h0000_0401;
        cycle();
        mtc0_we = 0;
        rst = 1;
        #1;
        checkOutput("arst_status", status_o, 32'h0040_0000);
        checkOutput("arst_epc", epc_o, 32'h0);
        checkOutput("arst_cause", cause_o, 32'h0);
        cycle();
        rst = 0;
        cycle(); cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
